silly_func_scanner: RTL and testbench
=====================================

// Module: silly_func_scanner
// PURPOSE
//  Sequential truth-table scanner for the 3-input silly_func logic block.
//  On start, drives every input combination (000..111) onto the DUT inputs,
//  waits a settle time, samples y, and builds the observed truth table.
//  Compares the result against the expected minterm set {0,4,5} (8'h31).
//  Sits beside the combinational block on the board/bench as its self-checker.
// PARAMETERS
//  N_IN          3      number of DUT inputs; vectors swept = 2**N_IN
//  SETTLE_CYCLES 1      cycles drv is held before y is sampled (must be >= 1)
//  EXPECTED      8'h31  expected truth table, bit k = f(k), width 2**N_IN
// PORTS
//  clk          in   1          rising-edge clock
//  reset        in   1          synchronous, active-high reset
//  start        in   1          begin scan; sampled only in IDLE
//  y_in         in   1          DUT output y
//  drv          out  N_IN       DUT inputs; drv[2]=a, drv[1]=b, drv[0]=c
//  busy         out  1          high in SETTLE/SAMPLE/DONE
//  done         out  1          one-cycle pulse when scan completes
//  truth_table  out  2**N_IN    observed table, bit k = y sampled with drv==k
//  pass         out  1          truth_table == EXPECTED, valid from done
//  mismatch     out  2**N_IN    truth_table ^ EXPECTED, valid from done
// BEHAVIOUR
//  Reset: state=IDLE; drv=0, busy=0, done=0, truth_table=0, pass=0, mismatch=0.
//  States: IDLE, SETTLE, SAMPLE, DONE. Internal idx (N_IN bits), cnt.
//  IDLE:   start=1 -> idx=0, drv=0, truth_table=0, pass=0, mismatch=0,
//          cnt=SETTLE_CYCLES-1, go SETTLE. start=0 -> stay; outputs held.
//  SETTLE: cnt==0 -> SAMPLE, else cnt--. drv stable = idx.
//  SAMPLE: truth_table[idx]<=y_in. idx==2**N_IN-1 -> DONE; else idx++,
//          drv<=idx+1, cnt=SETTLE_CYCLES-1, go SETTLE.
//  DONE:   done=1 (this cycle only); pass/mismatch registered from final
//          table; go IDLE. drv returns to 0 on IDLE entry.
//  Latency: start seen in IDLE at cycle 0 -> done high at cycle
//          2**N_IN*(SETTLE_CYCLES+1)+1 (17 for defaults).
//  start ignored outside IDLE (no queueing); held-high start -> back-to-back
//          scans, period 2**N_IN*(SETTLE_CYCLES+1)+2 cycles.
//  truth_table/pass/mismatch hold after done until next accepted start.
//  y_in sampled only in SAMPLE; glitches in SETTLE have no effect.
//  idx must not wrap: last vector exits to DONE, never to vector 0.
//  reset mid-scan: return to reset state next edge; no done pulse; partial
//          table discarded. reset dominates start in the same cycle.
// TESTING
//  1 silly_func on drv/y_in, defaults, start pulse -> done at cycle 17,
//    truth_table=8'h31, pass=1, mismatch=8'h00.
//  2 y_in tied 0 -> truth_table=8'h00, pass=0, mismatch=8'h31.
//  3 y_in = ~drv[2] model -> truth_table=8'h0F, pass=0, mismatch=8'h3E.
//  4 reset asserted at cycle 7 of scan -> next cycle drv=0, busy=0,
//    truth_table=0; no done; subsequent start scans cleanly to 8'h31.
//  5 SETTLE_CYCLES=3, y_in delayed 2 cycles from drv -> done at cycle 33,
//    truth_table=8'h31, pass=1.
//  6 start held high, silly_func DUT -> done pulses at cycles 17, 35, 53;
//    start pulses during busy never alter idx or timing.

Source files
------------

// File: rtl/silly_func_scanner_if.sv
// rtl/silly_func_scanner_if.sv - scanner control/observe bundle between the scanner and the block under scan
interface silly_func_scanner_if #(
    parameter int N_IN = 3
);
    logic                   start;
    logic                   y_in;
    logic [N_IN-1:0]        drv;
    logic                   busy;
    logic                   done;
    logic [(1<<N_IN)-1:0]   truth_table;
    logic                   pass;
    logic [(1<<N_IN)-1:0]   mismatch;

    modport master (
        input  start,
        input  y_in,
        output drv,
        output busy,
        output done,
        output truth_table,
        output pass,
        output mismatch
    );

    modport slave (
        output start,
        output y_in,
        input  drv,
        input  busy,
        input  done,
        input  truth_table,
        input  pass,
        input  mismatch
    );
endinterface

// File: rtl/silly_func_scanner.sv
// rtl/silly_func_scanner.sv - sweeps all input vectors of silly_func, records y, compares to expected table
module silly_func_scanner #(
    parameter int                  N_IN          = 3,
    parameter int                  SETTLE_CYCLES = 1,
    parameter logic [(1<<N_IN)-1:0] EXPECTED     = 'h31
) (
    input  logic                 clk,
    input  logic                 reset,
    silly_func_scanner_if.master bus
);
    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    state_t          state;
    logic [N_IN-1:0] idx;
    logic [CW-1:0]   cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            idx             <= '0;
            cnt             <= '0;
            bus.drv         <= '0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.truth_table <= '0;
            bus.pass        <= 1'b0;
            bus.mismatch    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        idx             <= '0;
                        cnt             <= CW'(SETTLE_CYCLES - 1);
                        bus.drv         <= '0;
                        bus.busy        <= 1'b1;
                        bus.truth_table <= '0;
                        bus.pass        <= 1'b0;
                        bus.mismatch    <= '0;
                        state           <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt == '0) begin
                        state <= SAMPLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                SAMPLE: begin
                    bus.truth_table[idx] <= bus.y_in;
                    // Last vector leaves to DONE so idx never wraps back to 0.
                    if (idx == {N_IN{1'b1}}) begin
                        state <= DONE;
                    end else begin
                        idx     <= idx + 1'b1;
                        bus.drv <= idx + 1'b1;
                        cnt     <= CW'(SETTLE_CYCLES - 1);
                        state   <= SETTLE;
                    end
                end
                DONE: begin
                    bus.done     <= 1'b1;
                    bus.pass     <= (bus.truth_table == EXPECTED);
                    bus.mismatch <= bus.truth_table ^ EXPECTED;
                    bus.drv      <= '0;
                    bus.busy     <= 1'b0;
                    state        <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_silly_func_scanner.sv
// tb/tb_silly_func_scanner.sv - scoreboard bench for silly_func_scanner with default and slow-settle instances
module tb_silly_func_scanner;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   mode = 0;
    logic d1 = 1'b0;
    logic d2 = 1'b0;

    typedef struct {
        logic [7:0] tt;
        int         cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q3[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    silly_func_scanner_if #(.N_IN(3)) if0 ();
    silly_func_scanner_if #(.N_IN(3)) if3 ();

    silly_func_scanner #(.N_IN(3), .SETTLE_CYCLES(1), .EXPECTED(8'h31)) u0 (
        .clk   (clk),
        .reset (reset),
        .bus   (if0.master)
    );

    silly_func_scanner #(.N_IN(3), .SETTLE_CYCLES(3), .EXPECTED(8'h31)) u3 (
        .clk   (clk),
        .reset (reset),
        .bus   (if3.master)
    );

    function automatic logic silly_f(logic [2:0] v);
        return ~v[1] & (v[2] | ~v[0]);
    endfunction

    function automatic logic [7:0] model_table(int m);
        logic [7:0] t;
        for (int k = 0; k < 8; k++) begin
            logic [2:0] v;
            v = 3'(k);
            case (m)
                0:       t[k] = silly_f(v);
                1:       t[k] = 1'b0;
                default: t[k] = ~v[2];
            endcase
        end
        return t;
    endfunction

    assign if0.y_in = (mode == 0) ? silly_f(if0.drv) : (mode == 1) ? 1'b0 : ~if0.drv[2];

    always @(posedge clk) begin
        d1 <= silly_f(if3.drv);
        d2 <= d1;
    end
    assign if3.y_in = d2;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    always @(negedge clk) begin : mon0
        exp_t e;
        if (!reset && if0.done) begin
            check("u0_done_expected", 32'(q0.size() != 0), 1);
            if (q0.size() != 0) begin
                e = q0.pop_front();
                check("u0_truth_table", 32'(if0.truth_table), 32'(e.tt));
                check("u0_pass", 32'(if0.pass), 32'(e.tt == 8'h31));
                check("u0_mismatch", 32'(if0.mismatch), 32'(e.tt ^ 8'h31));
                check("u0_done_cycle", cyc, e.cyc);
            end
        end
    end

    always @(negedge clk) begin : mon3
        exp_t e;
        if (!reset && if3.done) begin
            check("u3_done_expected", 32'(q3.size() != 0), 1);
            if (q3.size() != 0) begin
                e = q3.pop_front();
                check("u3_truth_table", 32'(if3.truth_table), 32'(e.tt));
                check("u3_pass", 32'(if3.pass), 32'(e.tt == 8'h31));
                check("u3_mismatch", 32'(if3.mismatch), 32'(e.tt ^ 8'h31));
                check("u3_done_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic pulse_start0(output int acc);
        @(negedge clk);
        if0.start = 1'b1;
        @(posedge clk);
        #1 acc = cyc;
        @(negedge clk);
        if0.start = 1'b0;
    endtask

    task automatic wait_until(input int target);
        for (int i = 0; i < 5000 && cyc < target; i++) @(negedge clk);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 2000 && (q0.size() + q3.size()) != 0; i++) @(negedge clk);
        check(tag, 32'(q0.size() + q3.size()), 0);
    endtask

    initial begin
        int acc;
        exp_t e;
        if0.start = 1'b0;
        if3.start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_drv", 32'(if0.drv), 0);
        check("rst_busy", 32'(if0.busy), 0);
        check("rst_done", 32'(if0.done), 0);
        check("rst_truth_table", 32'(if0.truth_table), 0);
        check("rst_pass", 32'(if0.pass), 0);
        check("rst_mismatch", 32'(if0.mismatch), 0);
        reset = 1'b0;

        // silly_func, with a stray start pulse mid-scan that must be ignored
        mode = 0;
        pulse_start0(acc);
        e.tt = model_table(0); e.cyc = acc + 17; q0.push_back(e);
        wait_until(acc + 5);
        check("busy_mid_scan", 32'(if0.busy), 1);
        if0.start = 1'b1;
        @(negedge clk);
        if0.start = 1'b0;
        drain("drain_silly");
        repeat (3) @(negedge clk);
        check("idle_after_silly", 32'(if0.busy), 0);
        check("drv_zero_idle", 32'(if0.drv), 0);

        mode = 1;
        pulse_start0(acc);
        e.tt = model_table(1); e.cyc = acc + 17; q0.push_back(e);
        drain("drain_zero");
        repeat (2) @(negedge clk);
        check("tt_hold_zero", 32'(if0.truth_table), 0);
        check("mismatch_hold_zero", 32'(if0.mismatch), 32'h31);

        mode = 2;
        pulse_start0(acc);
        e.tt = model_table(2); e.cyc = acc + 17; q0.push_back(e);
        drain("drain_not_a");

        // reset mid-scan, with start high alongside it
        mode = 0;
        pulse_start0(acc);
        wait_until(acc + 6);
        reset = 1'b1;
        if0.start = 1'b1;
        @(posedge clk);
        #1;
        check("abort_drv", 32'(if0.drv), 0);
        check("abort_busy", 32'(if0.busy), 0);
        check("abort_truth_table", 32'(if0.truth_table), 0);
        check("abort_done", 32'(if0.done), 0);
        @(negedge clk);
        reset = 1'b0;
        if0.start = 1'b0;
        repeat (25) @(negedge clk);
        check("abort_stays_idle", 32'(if0.busy), 0);
        pulse_start0(acc);
        e.tt = model_table(0); e.cyc = acc + 17; q0.push_back(e);
        drain("drain_after_abort");

        // slow-settle instance with delayed y
        @(negedge clk);
        if3.start = 1'b1;
        @(posedge clk);
        #1 acc = cyc;
        @(negedge clk);
        if3.start = 1'b0;
        e.tt = model_table(0); e.cyc = acc + 33; q3.push_back(e);
        drain("drain_settle3");

        // held start -> back-to-back scans
        mode = 0;
        @(negedge clk);
        if0.start = 1'b1;
        @(posedge clk);
        #1 acc = cyc;
        for (int k = 0; k < 3; k++) begin
            e.tt = model_table(0); e.cyc = acc + 17 + 18 * k; q0.push_back(e);
        end
        wait_until(acc + 53);
        if0.start = 1'b0;
        drain("drain_held");
        repeat (4) @(negedge clk);
        check("idle_after_held", 32'(if0.busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
